// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with oversampling and a 2-of-3 majority vote at mid-bit.
// Emits one-clock rx_rdy / frame_err strobes; a held-low line parks in BREAK.
module uart_rx_sampler #(
    parameter int FREQUENCY  = 11059200,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = FREQUENCY / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0   = SW'(M - 1);
    localparam logic [SW-1:0] S_V1   = SW'(M);
    localparam logic [SW-1:0] S_V2   = SW'(M + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_s;
    logic [1:0]    r_v;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_rdy;
    logic          r_ferr;

    logic w_rx_s;
    logic w_tick;
    logic w_start;
    logic w_vote_pt;
    logic w_wrap;
    logic w_vote;

    assign w_rx_s    = r_sync[1];
    assign w_tick    = (r_cnt == C_LAST);
    assign w_start   = (r_state == ST_IDLE) && !w_rx_s;
    assign w_vote_pt = w_tick && (r_s == S_V2);
    assign w_wrap    = w_tick && (r_s == S_LAST);
    assign w_vote    = (r_v[0] & r_v[1]) | (r_v[0] & w_rx_s) | (r_v[1] & w_rx_s);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Tick phase is re-aligned to the detected start edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt <= '0;
            r_s   <= '0;
            r_v   <= 2'b00;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_s   <= '0;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                if (w_tick) begin
                    r_s <= (r_s == S_LAST) ? '0 : r_s + SW'(1);
                end
            end
            if (w_tick && (r_s == S_V0)) begin
                r_v[0] <= w_rx_s;
            end
            if (w_tick && (r_s == S_V1)) begin
                r_v[1] <= w_rx_s;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_vote_pt && w_vote) begin
                    w_next = ST_IDLE;
                end else if (w_wrap) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_wrap && (r_bit == 3'd7)) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_vote_pt) begin
                    w_next = w_vote ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_tick && w_rx_s) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_byte  <= 8'h00;
            r_rdy   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rdy  <= 1'b0;
            r_ferr <= 1'b0;
            if ((r_state == ST_START) && w_wrap) begin
                r_bit <= 3'd0;
            end
            if (r_state == ST_DATA) begin
                if (w_vote_pt) begin
                    r_shift[r_bit] <= w_vote;
                end
                if (w_wrap && (r_bit != 3'd7)) begin
                    r_bit <= r_bit + 3'd1;
                end
            end
            if ((r_state == ST_STOP) && w_vote_pt) begin
                if (w_vote) begin
                    r_byte <= r_shift;
                    r_rdy  <= 1'b1;
                end else begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    assign rx_byte   = r_byte;
    assign rx_rdy    = r_rdy;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at 115200 baud (DIV=6, 96 clocks per bit).
// Random frames are scored against an expected-event queue built from the frame contents.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int BIT = 96;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       res;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_rdy;
    logic       frame_err;
    logic       busy;

    evt_t       exp_q[$];
    evt_t       e;
    int         checks     = 0;
    int         errors     = 0;
    int         n_unexp    = 0;
    logic [7:0] last_good  = 8'h00;
    logic       prev_pulse = 1'b0;

    always #45 clk = ~clk;

    uart_rx_sampler #(
        .FREQUENCY (11059200),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .res      (res),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_rdy   (rx_rdy),
        .frame_err(frame_err),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Each strobe must match the oldest frame still owed an outcome.
    always @(negedge clk) begin
        if (res) begin
            prev_pulse = 1'b0;
        end else begin
            if (rx_rdy || frame_err) begin
                chk("excl", 32'(rx_rdy & frame_err), 32'd0);
                if (prev_pulse) n_unexp++;
                if (exp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    e = exp_q.pop_front();
                    chk("kind", 32'(frame_err), 32'(e.err));
                    if (!e.err) begin
                        chk("rx_byte", 32'(rx_byte), 32'(e.data));
                        chk("busy_fall", 32'(busy), 32'd0);
                        last_good = e.data;
                    end else begin
                        chk("hold_byte", 32'(rx_byte), 32'(last_good));
                    end
                end
            end
            prev_pulse = rx_rdy || frame_err;
        end
    end

    task automatic hold(input int n, input logic v);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int jit);
        logic [9:0] bits;
        int         off[11];
        evt_t       ev;
        bits = {stop, d, 1'b0};
        off[0]  = 0;
        off[10] = 0;
        for (int i = 1; i < 10; i++) begin
            off[i] = (jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0;
        end
        ev.err  = !stop;
        ev.data = d;
        exp_q.push_back(ev);
        for (int i = 0; i < 10; i++) begin
            hold(BIT + off[i+1] - off[i], bits[i]);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        rx = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 4 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_unexp"}, 32'(n_unexp), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       bad;
        int         gap;

        res = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_byte", 32'(rx_byte), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        res = 1'b0;
        @(negedge clk);
        chk("rel_rdy", 32'(rx_rdy), 32'd0);
        chk("rel_ferr", 32'(frame_err), 32'd0);
        hold(3 * BIT, 1'b1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_byte", 32'(rx_byte), 32'h00);
        chk("idle_unexp", 32'(n_unexp), 32'd0);

        send_frame(8'h8C, 1'b1, 0);
        hold(BIT, 1'b1);
        drain("f8c");
        chk("f8c_byte", 32'(rx_byte), 32'h8C);

        hold(20, 1'b0);
        hold(BIT, 1'b1);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_unexp", 32'(n_unexp), 32'd0);

        send_frame(8'h55, 1'b0, 0);
        hold(BIT, 1'b1);
        chk("ferr_byte", 32'(rx_byte), 32'h8C);
        send_frame(8'hA5, 1'b1, 0);
        drain("fa5");
        chk("fa5_byte", 32'(rx_byte), 32'hA5);

        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hAA, 1'b1, 0);
        hold(BIT, 1'b0);
        hold(BIT, 1'b1);
        hold(BIT, 1'b0);
        hold(BIT / 2, 1'b1);
        chk("b2b_pending", 32'(exp_q.size()), 32'd0);
        chk("b2b_byte", 32'(rx_byte), 32'hAA);
        res = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_byte", 32'(rx_byte), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        last_good = 8'h00;
        res = 1'b0;
        hold(3 * BIT, 1'b1);
        chk("post_rst_rdy", 32'(rx_rdy), 32'd0);
        chk("post_rst_unexp", 32'(n_unexp), 32'd0);
        send_frame(8'h3C, 1'b1, 0);
        drain("f3c");

        send_frame(8'hF0, 1'b1, 0);
        drain("ff0");
        send_frame(8'hF0, 1'b1, 3);
        drain("ff0_jit");

        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(4) == 0);
            send_frame(d, !bad, int'($urandom_range(3)));
            gap = bad ? 1 + int'($urandom_range(1)) : int'($urandom_range(2));
            hold(gap * BIT, 1'b1);
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
